// File: rtl/button_press_multi_pkg.sv
// Shared FSM encodings and hold-seconds field sizing for the multi-button front end.
package button_press_multi_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_LONG  = 2'd2
  } btn_state_e;

  localparam int HOLD_SEC_W = 4;
  localparam logic [HOLD_SEC_W-1:0] HOLD_SEC_MAX = 4'd15;
endpackage

// File: rtl/button_press_multi_channel.sv
// One button channel: 2-FF sync, tick-based debounce, short/long classifier, held-seconds counter.
module button_channel
  import button_press_multi_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 3000,
  parameter int SEC_MS      = 1000
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  button,
  output logic                  pressed,
  output logic                  short_pulse,
  output logic                  long_pulse,
  output logic                  long_held,
  output logic [HOLD_SEC_W-1:0] hold_sec
);
  localparam int DEB_W  = $clog2(DEBOUNCE_MS + 1);
  localparam int HOLD_W = $clog2(LONG_MS + 1);
  localparam int SEC_W  = $clog2(SEC_MS + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MS - 1);
  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_MS - 1);

  logic              sync1, sync2;
  logic [DEB_W-1:0]  deb_cnt;
  logic [HOLD_W-1:0] hold_ms;
  logic [SEC_W-1:0]  sec_ms;
  btn_state_e        state, state_nx;
  logic              short_nx, long_nx;

  // Debounced level only follows the synced input after DEBOUNCE_MS consecutive disagreeing ticks.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb_cnt <= '0;
      pressed <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      if (sync2 == pressed) begin
        deb_cnt <= '0;
      end else if (tick) begin
        if (deb_cnt == DEB_LAST) begin
          pressed <= sync2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end
    end
  end

  // Release is checked first so a release coinciding with the long threshold reports short.
  always_comb begin
    state_nx = state;
    short_nx = 1'b0;
    long_nx  = 1'b0;
    case (state)
      ST_IDLE:  if (pressed) state_nx = ST_PRESS;
      ST_PRESS: begin
        if (!pressed) begin
          state_nx = ST_IDLE;
          short_nx = 1'b1;
        end else if (tick && hold_ms == HOLD_LAST) begin
          state_nx = ST_LONG;
          long_nx  = 1'b1;
        end
      end
      ST_LONG:  if (!pressed) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      hold_ms     <= '0;
      sec_ms      <= '0;
      hold_sec    <= '0;
    end else begin
      state       <= state_nx;
      short_pulse <= short_nx;
      long_pulse  <= long_nx;
      if (state == ST_IDLE) begin
        if (pressed) begin
          hold_ms  <= '0;
          sec_ms   <= '0;
          hold_sec <= '0;
        end
      end else if (pressed && tick) begin
        if (state == ST_PRESS) hold_ms <= hold_ms + 1'b1;
        if (sec_ms == SEC_LAST) begin
          sec_ms <= '0;
          if (hold_sec != HOLD_SEC_MAX) hold_sec <= hold_sec + 1'b1;
        end else begin
          sec_ms <= sec_ms + 1'b1;
        end
      end
    end
  end

  assign long_held = (state == ST_LONG);
endmodule

// File: rtl/button_press_multi.sv
// N-channel push-button front end: shared 1 ms tick prescaler feeding one button_channel per input.
module button_press_multi
  import button_press_multi_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 1000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 3000,
  parameter int SEC_MS      = 1000
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic [N_BTN-1:0]              button,
  output logic [N_BTN-1:0]              pressed,
  output logic [N_BTN-1:0]              short_pulse,
  output logic [N_BTN-1:0]              long_pulse,
  output logic [N_BTN-1:0]              long_held,
  output logic [HOLD_SEC_W*N_BTN-1:0]   hold_sec
);
  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  // With a ratio of 1 the counter stays at 0 and tick is asserted every cycle.
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk_in) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS),
      .SEC_MS      (SEC_MS)
    ) u_ch (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .tick        (tick),
      .button      (button[i]),
      .pressed     (pressed[i]),
      .short_pulse (short_pulse[i]),
      .long_pulse  (long_pulse[i]),
      .long_held   (long_held[i]),
      .hold_sec    (hold_sec[HOLD_SEC_W*i +: HOLD_SEC_W])
    );
  end
endmodule

// File: tb/tb_button_press_multi.sv
// Randomised and directed checks of button_press_multi against a press-duration reference model.
module tb_button_press_multi;
  localparam int N    = 4;
  localparam int CLKH = 1000;
  localparam int TICKH = 1000;
  localparam int DEB  = 4;
  localparam int LNG  = 20;
  localparam int SEC  = 5;
  localparam int DIV  = CLKH / TICKH;

  logic            clk_in = 1'b0;
  logic            rst_n;
  logic [N-1:0]    button;
  logic [N-1:0]    pressed, short_pulse, long_pulse, long_held;
  logic [4*N-1:0]  hold_sec;

  int total = 0;
  int bad   = 0;

  button_press_multi #(
    .N_BTN(N), .CLK_HZ(CLKH), .TICK_HZ(TICKH),
    .DEBOUNCE_MS(DEB), .LONG_MS(LNG), .SEC_MS(SEC)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .button(button),
    .pressed(pressed), .short_pulse(short_pulse), .long_pulse(long_pulse),
    .long_held(long_held), .hold_sec(hold_sec)
  );

  always #5 clk_in = ~clk_in;

  // Reference: a press is a stretch of debounced-high; its tick count drives long/hold_sec.
  bit m_s1[N], m_s2[N], m_p[N], m_act[N], m_lng[N];
  int m_run[N], m_ticks[N];
  int m_tcnt;
  logic [N-1:0]   e_p, e_s, e_l, e_h;
  logic [4*N-1:0] e_hs;

  task automatic model_step();
    bit tk, op;
    int hs;
    if (!rst_n) begin
      m_tcnt = 0;
      for (int i = 0; i < N; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_p[i] = 0; m_act[i] = 0; m_lng[i] = 0;
        m_run[i] = 0; m_ticks[i] = 0;
      end
      e_p = '0; e_s = '0; e_l = '0; e_h = '0; e_hs = '0;
    end else begin
      tk = (m_tcnt == DIV - 1);
      m_tcnt = tk ? 0 : m_tcnt + 1;
      for (int i = 0; i < N; i++) begin
        op = m_p[i];
        e_s[i] = 1'b0;
        e_l[i] = 1'b0;
        if (!m_act[i]) begin
          if (op) begin m_act[i] = 1; m_ticks[i] = 0; m_lng[i] = 0; end
        end else if (!op) begin
          if (!m_lng[i]) e_s[i] = 1'b1;
          m_act[i] = 0;
        end else if (tk) begin
          m_ticks[i]++;
          if (m_ticks[i] == LNG && !m_lng[i]) begin m_lng[i] = 1; e_l[i] = 1'b1; end
        end
        if (m_s2[i] != op) begin
          if (tk) m_run[i]++;
          if (m_run[i] == DEB) begin m_p[i] = m_s2[i]; m_run[i] = 0; end
        end else begin
          m_run[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = button[i];
        hs = m_ticks[i] / SEC;
        if (hs > 15) hs = 15;
        e_p[i] = m_p[i];
        e_h[i] = m_act[i] && m_lng[i];
        e_hs[4*i +: 4] = 4'(hs);
      end
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    button = 4'hF;
    for (int k = 0; k < 3; k++) begin
      step();
      if ({pressed, short_pulse, long_pulse, long_held, hold_sec} !== 32'h0) begin
        bad++;
        $display("FAIL reset cyc=%0d got=%h exp=0", k, {pressed, short_pulse, long_pulse, long_held, hold_sec});
      end
      total++;
    end
    rst_n = 1'b1;
    button = 4'h0;
    for (int k = 0; k < 10; k++) begin
      step();
      if ({pressed, short_pulse, long_pulse, long_held, hold_sec} !== {e_p, e_s, e_l, e_h, e_hs}) begin
        bad++;
        $display("FAIL reset_settle cyc=%0d got=%h exp=%h", k,
                 {pressed, short_pulse, long_pulse, long_held, hold_sec}, {e_p, e_s, e_l, e_h, e_hs});
      end
      total++;
    end
  endtask

  task automatic test_glitch();
    int saw = 0;
    for (int k = 0; k < 15; k++) begin
      button[0] = (k < 3);
      step();
      if (pressed[0] || short_pulse[0] || long_pulse[0]) saw++;
      if ({pressed, short_pulse, long_pulse, long_held, hold_sec} !== {e_p, e_s, e_l, e_h, e_hs}) begin
        bad++;
        $display("FAIL glitch cyc=%0d got=%h exp=%h", k,
                 {pressed, short_pulse, long_pulse, long_held, hold_sec}, {e_p, e_s, e_l, e_h, e_hs});
      end
      total++;
    end
    if (saw !== 0) begin bad++; $display("FAIL glitch_activity got=%0d exp=0", saw); end
    total++;
  endtask

  task automatic test_short();
    int rise_k = -1, short_k = -1, n_short = 0, n_long = 0;
    for (int k = 0; k < 25; k++) begin
      button[0] = (k < 10);
      step();
      if (pressed[0] && rise_k < 0) rise_k = k;
      if (short_pulse[0]) begin n_short++; short_k = k; end
      if (long_pulse[0]) n_long++;
      if ({pressed, short_pulse, long_pulse, long_held, hold_sec} !== {e_p, e_s, e_l, e_h, e_hs}) begin
        bad++;
        $display("FAIL short cyc=%0d got=%h exp=%h", k,
                 {pressed, short_pulse, long_pulse, long_held, hold_sec}, {e_p, e_s, e_l, e_h, e_hs});
      end
      total++;
    end
    if (rise_k !== 5) begin bad++; $display("FAIL short_rise_latency got=%0d exp=5", rise_k); end
    total++;
    if (short_k !== 16 || n_short !== 1 || n_long !== 0) begin
      bad++;
      $display("FAIL short_pulse_count at=%0d n=%0d long=%0d exp at=16 n=1 long=0", short_k, n_short, n_long);
    end
    total++;
  endtask

  task automatic test_long();
    int n_short = 0, n_long = 0, long_k = -1, held_cyc = 0;
    for (int k = 0; k < 60; k++) begin
      button[1] = (k < 40);
      step();
      if (long_pulse[1]) begin n_long++; long_k = k; end
      if (short_pulse[1]) n_short++;
      if (long_held[1]) held_cyc++;
      if ({pressed, short_pulse, long_pulse, long_held, hold_sec} !== {e_p, e_s, e_l, e_h, e_hs}) begin
        bad++;
        $display("FAIL long cyc=%0d got=%h exp=%h", k,
                 {pressed, short_pulse, long_pulse, long_held, hold_sec}, {e_p, e_s, e_l, e_h, e_hs});
      end
      total++;
    end
    if (n_long !== 1 || long_k !== 26 || n_short !== 0) begin
      bad++;
      $display("FAIL long_pulse_count n=%0d at=%0d short=%0d exp n=1 at=26 short=0", n_long, long_k, n_short);
    end
    total++;
    if (held_cyc !== 20) begin bad++; $display("FAIL long_held_len got=%0d exp=20", held_cyc); end
    total++;
    if (hold_sec[7:4] !== 4'd7) begin bad++; $display("FAIL long_hold_sec got=%0d exp=7", hold_sec[7:4]); end
    total++;
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 110; k++) begin
      button[2] = (k < 100);
      step();
      if ({pressed, short_pulse, long_pulse, long_held, hold_sec} !== {e_p, e_s, e_l, e_h, e_hs}) begin
        bad++;
        $display("FAIL saturate cyc=%0d got=%h exp=%h", k,
                 {pressed, short_pulse, long_pulse, long_held, hold_sec}, {e_p, e_s, e_l, e_h, e_hs});
      end
      total++;
    end
    if (hold_sec[11:8] !== 4'd15) begin bad++; $display("FAIL saturate_hold_sec got=%0d exp=15", hold_sec[11:8]); end
    total++;
  endtask

  task automatic test_reset_mid();
    int n_ch3 = 0, n_ch0 = 0;
    for (int k = 0; k < 45; k++) begin
      button[0] = (k < 8);
      button[3] = (k < 22);
      rst_n = !(k == 20 || k == 21);
      step();
      if (short_pulse[3] || long_pulse[3]) n_ch3++;
      if (short_pulse[0]) n_ch0++;
      if (!rst_n && {pressed, short_pulse, long_pulse, long_held, hold_sec} !== 32'h0) begin
        bad++;
        $display("FAIL reset_mid_clear cyc=%0d got=%h exp=0", k, {pressed, short_pulse, long_pulse, long_held, hold_sec});
      end
      if ({pressed, short_pulse, long_pulse, long_held, hold_sec} !== {e_p, e_s, e_l, e_h, e_hs}) begin
        bad++;
        $display("FAIL reset_mid cyc=%0d got=%h exp=%h", k,
                 {pressed, short_pulse, long_pulse, long_held, hold_sec}, {e_p, e_s, e_l, e_h, e_hs});
      end
      total++;
    end
    rst_n = 1'b1;
    if (n_ch3 !== 0 || n_ch0 !== 1) begin
      bad++;
      $display("FAIL reset_mid_pulses ch3=%0d ch0=%0d exp ch3=0 ch0=1", n_ch3, n_ch0);
    end
    total++;
  endtask

  task automatic test_random();
    int rem[N];
    for (int i = 0; i < N; i++) rem[i] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0) begin
          button[i] = ~button[i];
          rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 45);
        end
        rem[i]--;
      end
      rst_n = ($urandom_range(0, 699) != 0);
      step();
      if ({pressed, short_pulse, long_pulse, long_held, hold_sec} !== {e_p, e_s, e_l, e_h, e_hs}) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h exp=%h", k,
                 {pressed, short_pulse, long_pulse, long_held, hold_sec}, {e_p, e_s, e_l, e_h, e_hs});
      end
      total++;
    end
    rst_n = 1'b1;
    button = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    button = '0;
    test_reset();
    test_glitch();
    test_short();
    test_long();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
